dma_bus_controller: RTL

- Memory-to-memory DMA engine and bus arbiter between the CPU data port and the data-RAM/IO bus.
- Copies 1–256 bytes between any 16-bit addresses (d_ram 0x0000–0x07FF, IO 0x1000–0x10FF, VRAM 0x2000+) by stealing bus cycles.
- CPU has priority at every arbitration point.
- Registers sit in the IO page; reg_dout is ORed into the IO read mux with the other peripherals.

---
 rtl/dma_bus_controller.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/dma_bus_controller.sv
// Cycle-stealing memory-to-memory DMA engine and CPU/DMA bus arbiter.
// CPU wins every arbitration slot; DMA moves one byte per ARB-RD-CAP-WR.
module dma_bus_controller #(
   parameter logic [7:0] DMA_ADDRESS = 8'h10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  cpu_din,
   input  logic [15:0] cpu_address,
   input  logic        cpu_w_en,
   input  logic        cpu_r_en,
   output logic [7:0]  cpu_dout,
   output logic        cpu_stall,
   output logic [7:0]  bus_din,
   output logic [15:0] bus_address,
   output logic        bus_w_en,
   output logic        bus_r_en,
   input  logic [7:0]  bus_dout,
   output logic [7:0]  reg_dout,
   output logic        done_flag,
   input  logic        done_flag_clr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_RD,
      S_CAP,
      S_WR
   } state_t;

   state_t      state;
   logic [7:0]  src_lo;
   logic [7:0]  src_hi;
   logic [7:0]  dst_lo;
   logic [7:0]  dst_hi;
   logic [7:0]  count;
   logic        src_inc;
   logic        dst_inc;
   logic [15:0] src_ptr;
   logic [15:0] dst_ptr;
   logic [8:0]  remaining;
   logic [7:0]  data_latch;

   logic [7:0]  offset;
   logic        sel;
   logic        busy;
   logic        dma_own;
   logic        reg_wr;
   logic        reg_rd;
   logic        ctrl_wr;
   logic        start;
   logic        abort;
   logic [7:0]  rd_val;

   // Offset wraps for addresses below the base, so one compare suffices.
   assign offset  = cpu_address[7:0] - DMA_ADDRESS;
   assign sel     = (cpu_address[15:8] == 8'h10) && (offset < 8'd6);
   assign busy    = (state != S_IDLE);
   assign dma_own = (state == S_RD) || (state == S_CAP) ||
                    (state == S_WR);
   assign reg_wr  = cpu_w_en && sel && !dma_own;
   assign reg_rd  = cpu_r_en && sel && !dma_own;
   assign ctrl_wr = reg_wr && (offset[2:0] == 3'd5);
   assign start   = ctrl_wr && cpu_din[0] && !cpu_din[7] &&
                    (state == S_IDLE);
   assign abort   = ctrl_wr && cpu_din[7] && (state == S_ARB);

   assign cpu_stall = dma_own;
   assign cpu_dout  = bus_dout;

   always_comb begin
      rd_val = 8'h00;
      case (offset[2:0])
         3'd0: rd_val = src_lo;
         3'd1: rd_val = src_hi;
         3'd2: rd_val = dst_lo;
         3'd3: rd_val = dst_hi;
         3'd4: rd_val = count;
         3'd5: rd_val = {4'h0, dst_inc, src_inc, done_flag, busy};
         default: rd_val = 8'h00;
      endcase
   end

   always_comb begin
      bus_address = cpu_address;
      bus_din     = cpu_din;
      bus_w_en    = cpu_w_en;
      bus_r_en    = cpu_r_en;
      unique case (state)
         S_RD: begin
            bus_address = src_ptr;
            bus_din     = 8'h00;
            bus_w_en    = 1'b0;
            bus_r_en    = 1'b1;
         end
         S_CAP: begin
            bus_address = src_ptr;
            bus_din     = 8'h00;
            bus_w_en    = 1'b0;
            bus_r_en    = 1'b0;
         end
         S_WR: begin
            bus_address = dst_ptr;
            bus_din     = data_latch;
            bus_w_en    = 1'b1;
            bus_r_en    = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         src_lo     <= 8'h00;
         src_hi     <= 8'h00;
         dst_lo     <= 8'h00;
         dst_hi     <= 8'h00;
         count      <= 8'h00;
         src_inc    <= 1'b0;
         dst_inc    <= 1'b0;
         src_ptr    <= 16'h0000;
         dst_ptr    <= 16'h0000;
         remaining  <= 9'd0;
         data_latch <= 8'h00;
         done_flag  <= 1'b0;
         reg_dout   <= 8'h00;
      end else begin
         reg_dout <= reg_rd ? rd_val : 8'h00;

         if (reg_wr && !busy) begin
            case (offset[2:0])
               3'd0: src_lo <= cpu_din;
               3'd1: src_hi <= cpu_din;
               3'd2: dst_lo <= cpu_din;
               3'd3: dst_hi <= cpu_din;
               3'd4: count  <= cpu_din;
               default: ;
            endcase
         end

         if (ctrl_wr && !busy) begin
            src_inc <= cpu_din[1];
            dst_inc <= cpu_din[2];
         end

         // Later assignments below win: a final WR beats a clear.
         if (done_flag_clr)
            done_flag <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  src_ptr   <= {src_hi, src_lo};
                  dst_ptr   <= {dst_hi, dst_lo};
                  remaining <= (count == 8'h00) ? 9'd256
                                                : {1'b0, count};
                  done_flag <= 1'b0;
                  state     <= S_ARB;
               end
            end
            S_ARB: begin
               if (abort)
                  state <= S_IDLE;
               else if (!cpu_r_en && !cpu_w_en)
                  state <= S_RD;
            end
            S_RD: state <= S_CAP;
            S_CAP: begin
               data_latch <= bus_dout;
               state      <= S_WR;
            end
            S_WR: begin
               remaining <= remaining - 9'd1;
               src_ptr   <= src_ptr + {15'h0000, src_inc};
               dst_ptr   <= dst_ptr + {15'h0000, dst_inc};
               if (remaining == 9'd1) begin
                  done_flag <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  state <= S_ARB;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
